// File: rtl/loopback_test_pkg.sv
// Shared definitions for the I/O loopback tester: echo mode codes and sizing helpers.
package loopback_test_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_TOGGLE = 2'd0;
    localparam mode_t MODE_FOLLOW = 2'd1;
    localparam mode_t MODE_INVERT = 2'd2;
    localparam mode_t MODE_HOLD   = 2'd3;

    // Ceiling log2; clog2(1) is 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // The filter counter has to hold values up to FILT_CYCLES.
    function automatic int unsigned filt_cnt_width(input int unsigned filt_cycles);
        int unsigned w;
        w = clog2(filt_cycles + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/io_sync_filter.sv
// One loopback channel front end: synchroniser chain, glitch filter and edge detection.
module io_sync_filter
    import loopback_test_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = filt_cnt_width(FILT_CYCLES);
    localparam logic [CntW-1:0] FiltLimit = CntW'(FILT_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_level;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [CntW-1:0]        cnt_inc;
    logic                   filt_q, filt_d;
    logic                   filt_dly_q;

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign cnt_inc    = cnt_q + CntW'(1);

    // Shift the raw pin into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    // Accept a new level only after it has differed from the old one for FILT_CYCLES cycles.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync_level != filt_q) begin
            if (cnt_inc == FiltLimit) begin
                filt_d = sync_level;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end else begin
            // Level returned before acceptance: the glitch is dropped.
            cnt_d = '0;
        end
    end

    // Filter state plus a one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
        end
    end

    assign level_o = filt_q;
    assign rise_o  = filt_q & ~filt_dly_q;
    assign fall_o  = ~filt_q & filt_dly_q;

endmodule

// File: rtl/io_loopback_tester.sv
// Board-level I/O loopback engine: filtered pin echo, per-channel edge counters,
// sticky activity flags and a slow LED pattern driven by one channel's rising edges.
module io_loopback_tester
    import loopback_test_pkg::*;
#(
    parameter int unsigned NUM_CH      = 7,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 3,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned LED_CH      = 6,
    parameter int unsigned LED_WIDTH   = 11
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    mode,
    input  logic                          clear,
    input  logic [NUM_CH-1:0]             ch_in,
    output logic [NUM_CH-1:0]             ch_out,
    output logic [NUM_CH*CNT_WIDTH-1:0]   edge_cnt,
    output logic [NUM_CH-1:0]             active,
    output logic [2:0]                    led_pattern
);

    logic [NUM_CH-1:0] filt;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;

    logic [NUM_CH-1:0]                ch_out_q, ch_out_d;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]                active_q, active_d;
    logic [LED_WIDTH-1:0]             led_cnt_q, led_cnt_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        io_sync_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES)
        ) u_filter (
            .clk     (clk),
            .reset   (reset),
            .pin_i   (ch_in[g]),
            .level_o (filt[g]),
            .rise_o  (rise[g]),
            .fall_o  (fall[g])
        );

        // A filtered level cannot rise and fall in the same cycle.
        a_edge_exclusive: assert property (@(posedge clk) disable iff (reset)
            !(rise[g] && fall[g]));
    end

    // Echo output next state; a mode change never reinitialises ch_out.
    always_comb begin
        ch_out_d = ch_out_q;
        unique case (mode)
            MODE_TOGGLE: ch_out_d = ch_out_q ^ rise;
            MODE_FOLLOW: ch_out_d = filt;
            MODE_INVERT: ch_out_d = ~filt;
            MODE_HOLD:   ch_out_d = ch_out_q;
        endcase
    end

    // Saturating edge counters and sticky flags; clear wins over a coincident rise.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (clear) begin
                cnt_d[i]    = '0;
                active_d[i] = 1'b0;
            end else if (rise[i]) begin
                active_d[i] = 1'b1;
                if (cnt_q[i] != {CNT_WIDTH{1'b1}}) begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // LED counter wraps freely; only its top three bits are visible.
    always_comb begin
        led_cnt_d = led_cnt_q;
        if (clear) begin
            led_cnt_d = '0;
        end else if (rise[LED_CH]) begin
            led_cnt_d = led_cnt_q + LED_WIDTH'(1);
        end
    end

    // Register all observable state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_out_q  <= '0;
            cnt_q     <= '0;
            active_q  <= '0;
            led_cnt_q <= '0;
        end else begin
            ch_out_q  <= ch_out_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            led_cnt_q <= led_cnt_d;
        end
    end

    assign ch_out      = ch_out_q;
    assign edge_cnt    = cnt_q;
    assign active      = active_q;
    assign led_pattern = led_cnt_q[LED_WIDTH-1 -: 3];

endmodule
